// File: rtl/dffs_port_master.sv
// dffs_port_master: initiator for the dffs single-port array.
// Request stream in, array strobes out, read data back on a response stream.
module dffs_port_master #(
    parameter int              SIZE     = 5,
    parameter int              WLEN     = 32,
    parameter bit              CLEAR_EN = 1'b1,
    parameter logic [WLEN-1:0] INIT_VAL = '0
) (
    input  logic            CLK,
    input  logic            RSTN,
    output logic            INIT_DONE,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WE,
    input  logic [SIZE-1:0] REQ_ADDR,
    input  logic [WLEN-1:0] REQ_DATA,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [WLEN-1:0] RSP_DATA,
    output logic            MEM_CEN,
    output logic [SIZE-1:0] MEM_A,
    output logic            MEM_WEN,
    output logic [WLEN-1:0] MEM_D,
    input  logic [WLEN-1:0] MEM_Q
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [WLEN-1:0] e0_q, e0_d;
    logic [WLEN-1:0] e1_q, e1_d;

    logic       clearing;
    logic       running;
    logic       pop;
    logic       fire;
    logic       credit;
    logic [2:0] occ;
    logic [1:0] fcnt_pop;

    // Handshake, credit and array strobes; everything is masked while in reset
    always_comb begin
        clearing  = RSTN & (state_q == S_CLEAR);
        running   = RSTN & (state_q == S_RUN);
        RSP_VALID = RSTN & (fcnt_q != 2'd0);
        RSP_DATA  = RSTN ? e0_q : '0;
        INIT_DONE = running;
        pop       = RSP_VALID & RSP_READY;
        occ       = {1'b0, fcnt_q} + {2'b00, pend_q} - {2'b00, pop};
        credit    = occ < 3'd2;
        REQ_READY = running & (REQ_WE | credit);
        fire      = REQ_VALID & REQ_READY;
        MEM_CEN   = 1'b1;
        MEM_WEN   = 1'b1;
        MEM_A     = '0;
        MEM_D     = '0;
        if (clearing) begin
            MEM_CEN = 1'b0;
            MEM_WEN = 1'b0;
            MEM_A   = cnt_q;
            MEM_D   = INIT_VAL;
        end else if (fire) begin
            MEM_CEN = 1'b0;
            MEM_WEN = ~REQ_WE;
            MEM_A   = REQ_ADDR;
            MEM_D   = REQ_DATA;
        end
    end

    // Next state: sweep counter, read-pending flag and the 2-entry shift FIFO
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = fire & ~REQ_WE;
        fcnt_pop = fcnt_q;
        e0_d     = e0_q;
        e1_d     = e1_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {SIZE{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        if (pop) begin
            e0_d     = e1_q;
            fcnt_pop = fcnt_q - 2'd1;
        end
        fcnt_d = fcnt_pop;
        // MEM_Q is the array output for the read accepted last cycle
        if (pend_q) begin
            if (fcnt_pop == 2'd0) begin
                e0_d = MEM_Q;
            end else begin
                e1_d = MEM_Q;
            end
            fcnt_d = fcnt_pop + 2'd1;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= CLEAR_EN ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fcnt_q  <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule
